// File: rtl/m65c02a_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : m65c02a_mem_arbiter
//  Purpose  : Shares one 8-bit external memory port between the M65C02A core
//             and a single DMA requester. Inserts per-region wait states,
//             stalls the core through Wait, alternates priority on contention.
//  Revision : 1.0 - initial release
// ============================================================================
module m65c02a_mem_arbiter #(
    parameter int          RAM_WS   = 0,
    parameter int          ROM_WS   = 2,
    parameter int          IO_WS    = 3,
    parameter logic [15:0] ROM_BASE = 16'hF000,
    parameter logic [7:0]  IO_PAGE  = 8'hFE
) (
    input  logic        Clk,
    input  logic        nRst,
    input  logic [1:0]  IO_Op,
    input  logic [15:0] AO,
    input  logic [7:0]  DO,
    input  logic        Lock,
    output logic        Wait,
    output logic [7:0]  DI,
    input  logic        DMA_Req,
    input  logic        DMA_Wr,
    input  logic [15:0] DMA_Addr,
    input  logic [7:0]  DMA_DO,
    output logic        DMA_Ack,
    output logic [7:0]  DMA_DI,
    output logic        MemCE,
    output logic        MemWE,
    output logic        MemOE,
    output logic [15:0] MemA,
    output logic [7:0]  MemDO,
    input  logic [7:0]  MemDI
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_DMA  = 2'd2;

    // Wait-state count for an address; the IO page wins over the ROM window.
    function automatic logic [1:0] region_ws(input logic [15:0] addr);
        if (addr[15:8] == IO_PAGE)
            region_ws = 2'(IO_WS);
        else if (addr >= ROM_BASE)
            region_ws = 2'(ROM_WS);
        else
            region_ws = 2'(RAM_WS);
    endfunction

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_dma_q, last_dma_d;
    logic [15:0] own_a_q, own_a_d;
    logic [7:0]  own_d_q, own_d_d;
    logic        own_wr_q, own_wr_d;
    logic [7:0]  di_q, di_d;
    logic [7:0]  dma_di_q, dma_di_d;

    logic        w_busy, w_cur_done, w_boundary;
    logic        w_cpu_done_cur, w_dma_done_cur;
    logic        w_creq, w_dreq, w_last;
    logic        w_g_cpu, w_g_dma, w_new_now;
    logic [15:0] w_g_addr;
    logic [7:0]  w_g_data;
    logic        w_g_wr;
    logic [1:0]  w_g_ws;
    logic        w_cpu_done, w_dma_done;
    logic        w_ce, w_wr;
    logic [15:0] w_a;
    logic [7:0]  w_do;

    // Arbitration: the owner of a completing slot is already being served, so
    // its still-asserted request is excluded; LastDMA is taken from the slot
    // that completes this cycle so alternation holds without a bubble.
    always_comb begin
        w_busy         = (state_q != ST_IDLE);
        w_cur_done     = w_busy && (cnt_q == 2'd0);
        w_boundary     = !w_busy || w_cur_done;
        w_cpu_done_cur = w_cur_done && (state_q == ST_CPU);
        w_dma_done_cur = w_cur_done && (state_q == ST_DMA);
        w_creq         = (IO_Op != 2'b00) && !w_cpu_done_cur;
        w_dreq         = DMA_Req && !Lock && !w_dma_done_cur;
        w_last         = w_cur_done ? (state_q == ST_DMA) : last_dma_q;
        w_g_dma        = w_boundary && w_dreq && (!w_creq || !w_last);
        w_g_cpu        = w_boundary && w_creq && !w_g_dma;
        w_g_addr       = w_g_dma ? DMA_Addr : AO;
        w_g_data       = w_g_dma ? DMA_DO : DO;
        w_g_wr         = w_g_dma ? DMA_Wr : (IO_Op == 2'b01);
        w_g_ws         = region_ws(w_g_addr);
        w_new_now      = !w_busy && (w_g_cpu || w_g_dma);
        w_cpu_done     = w_cpu_done_cur || (w_new_now && w_g_cpu && (w_g_ws == 2'd0));
        w_dma_done     = w_dma_done_cur || (w_new_now && w_g_dma && (w_g_ws == 2'd0));
    end

    // Bus mux: a running slot drives latched owner values, a slot granted from
    // IDLE drives the live requester values, otherwise the bus is quiet.
    always_comb begin
        w_ce = w_busy || w_new_now;
        w_a  = 16'h0000;
        w_do = 8'h00;
        w_wr = 1'b0;
        if (w_busy) begin
            w_a  = own_a_q;
            w_do = own_d_q;
            w_wr = own_wr_q;
        end else if (w_new_now) begin
            w_a  = w_g_addr;
            w_do = w_g_data;
            w_wr = w_g_wr;
        end
    end

    // Outputs are forced low while reset is asserted, independent of the clock.
    always_comb begin
        MemCE   = nRst && w_ce;
        MemWE   = nRst && w_ce && w_wr;
        MemOE   = nRst && w_ce && !w_wr;
        MemA    = nRst ? w_a  : 16'h0000;
        MemDO   = nRst ? w_do : 8'h00;
        Wait    = nRst && (IO_Op != 2'b00) && !w_cpu_done;
        DMA_Ack = nRst && w_dma_done;
        DI      = di_q;
        DMA_DI  = dma_di_q;
    end

    // Next-state: start, count down and hand over slots; capture read data.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        own_a_d    = own_a_q;
        own_d_d    = own_d_q;
        own_wr_d   = own_wr_q;
        last_dma_d = last_dma_q;
        di_d       = di_q;
        dma_di_d   = dma_di_q;
        if (!w_busy) begin
            if (w_new_now && (w_g_ws != 2'd0)) begin
                state_d  = w_g_dma ? ST_DMA : ST_CPU;
                cnt_d    = w_g_ws - 2'd1;
                own_a_d  = w_g_addr;
                own_d_d  = w_g_data;
                own_wr_d = w_g_wr;
            end
        end else if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end else begin
            // Grant made in a completion cycle takes the bus on the next
            // cycle, so the full 1+WS length is still counted from there.
            state_d = ST_IDLE;
            if (w_g_cpu || w_g_dma) begin
                state_d  = w_g_dma ? ST_DMA : ST_CPU;
                cnt_d    = w_g_ws;
                own_a_d  = w_g_addr;
                own_d_d  = w_g_data;
                own_wr_d = w_g_wr;
            end
        end
        if (w_cpu_done) begin
            last_dma_d = 1'b0;
            if (!w_wr)
                di_d = MemDI;
        end
        if (w_dma_done) begin
            last_dma_d = 1'b1;
            if (!w_wr)
                dma_di_d = MemDI;
        end
    end

    // State registers with asynchronous abort on reset.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            last_dma_q <= 1'b0;
            own_a_q    <= 16'h0000;
            own_d_q    <= 8'h00;
            own_wr_q   <= 1'b0;
            di_q       <= 8'h00;
            dma_di_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_dma_q <= last_dma_d;
            own_a_q    <= own_a_d;
            own_d_q    <= own_d_d;
            own_wr_q   <= own_wr_d;
            di_q       <= di_d;
            dma_di_q   <= dma_di_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m65c02a_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m65c02a_mem_arbiter
//  Purpose  : Directed self-checking bench for the core/DMA memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_m65c02a_mem_arbiter;

    logic        Clk = 1'b0;
    logic        nRst;
    logic [1:0]  IO_Op;
    logic [15:0] AO;
    logic [7:0]  DO;
    logic        Lock;
    logic        Wait;
    logic [7:0]  DI;
    logic        DMA_Req;
    logic        DMA_Wr;
    logic [15:0] DMA_Addr;
    logic [7:0]  DMA_DO;
    logic        DMA_Ack;
    logic [7:0]  DMA_DI;
    logic        MemCE;
    logic        MemWE;
    logic        MemOE;
    logic [15:0] MemA;
    logic [7:0]  MemDO;
    logic [7:0]  MemDI;

    int checks = 0;
    int errors = 0;

    m65c02a_mem_arbiter dut (
        .Clk(Clk), .nRst(nRst), .IO_Op(IO_Op), .AO(AO), .DO(DO), .Lock(Lock),
        .Wait(Wait), .DI(DI), .DMA_Req(DMA_Req), .DMA_Wr(DMA_Wr),
        .DMA_Addr(DMA_Addr), .DMA_DO(DMA_DO), .DMA_Ack(DMA_Ack), .DMA_DI(DMA_DI),
        .MemCE(MemCE), .MemWE(MemWE), .MemOE(MemOE), .MemA(MemA), .MemDO(MemDO),
        .MemDI(MemDI)
    );

    always #5 Clk = ~Clk;

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        nRst = 1'b0; IO_Op = 2'b10; AO = 16'h0200; DO = 8'h00; Lock = 1'b0;
        DMA_Req = 1'b1; DMA_Wr = 1'b0; DMA_Addr = 16'h0300; DMA_DO = 8'h00;
        MemDI = 8'hAA;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({Wait, DMA_Ack, MemCE, MemWE, MemOE} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b want 00000", {Wait, DMA_Ack, MemCE, MemWE, MemOE});
        end
        checks++;
        if ({MemA, MemDO, DI, DMA_DI} !== 40'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0000000000", {MemA, MemDO, DI, DMA_DI});
        end
        next_cycle();
        IO_Op = 2'b00;
        nRst  = 1'b1;
        @(negedge Clk);
        checks++;
        if ({MemCE, MemOE, DMA_Ack, MemA} !== {3'b111, 16'h0300}) begin
            errors++;
            $display("FAIL reset_first_grant got ce/oe/ack=%b%b%b a=%h want 111 0300",
                     MemCE, MemOE, DMA_Ack, MemA);
        end
        next_cycle();
        DMA_Req = 1'b0;
        checks++;
        if (DMA_DI !== 8'hAA) begin
            errors++;
            $display("FAIL reset_dma_di got %h want aa", DMA_DI);
        end
    endtask

    task automatic test_ram_read();
        IO_Op = 2'b10; AO = 16'h0200; MemDI = 8'h5A;
        @(negedge Clk);
        checks++;
        if ({Wait, MemOE, MemWE, MemA} !== {3'b010, 16'h0200}) begin
            errors++;
            $display("FAIL ram_read got wait/oe/we=%b%b%b a=%h want 010 0200",
                     Wait, MemOE, MemWE, MemA);
        end
        next_cycle();
        IO_Op = 2'b00;
        checks++;
        if (DI !== 8'h5A) begin
            errors++;
            $display("FAIL ram_read_di got %h want 5a", DI);
        end
        @(negedge Clk);
        checks++;
        if (MemCE !== 1'b0) begin
            errors++;
            $display("FAIL ram_read_idle got ce=%b want 0", MemCE);
        end
        next_cycle();
    endtask

    task automatic test_regions();
        logic [1:0]  ops   [7] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [15:0] addrs [7] = '{16'hFFFC, 16'hFE10, 16'hEFFF, 16'hF000,
                                   16'hFEFF, 16'hFF00, 16'hFDFF};
        int          exp_ws[7] = '{2, 3, 0, 2, 3, 2, 2};
        logic [7:0]  last_rd;
        last_rd = 8'h5A;
        for (int i = 0; i < 7; i++) begin
            int  n_wait;
            int  n_strobe;
            int  n_bad;
            logic [7:0] rd;
            n_wait = 0; n_strobe = 0; n_bad = 0;
            rd = 8'h30 + 8'(i);
            IO_Op = ops[i]; AO = addrs[i]; DO = 8'h77; MemDI = rd;
            for (int k = 0; k < 8; k++) begin
                @(negedge Clk);
                if ((ops[i] == 2'b01) ? (MemWE === 1'b1) : (MemOE === 1'b1))
                    n_strobe++;
                if (MemA !== addrs[i] || (ops[i] == 2'b01 && MemDO !== 8'h77))
                    n_bad++;
                if (Wait === 1'b1)
                    n_wait++;
                else
                    break;
                next_cycle();
            end
            checks++;
            if (n_wait != exp_ws[i]) begin
                errors++;
                $display("FAIL region_wait[%h] got %0d want %0d", addrs[i], n_wait, exp_ws[i]);
            end
            checks++;
            if (n_strobe != exp_ws[i] + 1 || n_bad != 0) begin
                errors++;
                $display("FAIL region_strobe[%h] got %0d bad %0d want %0d bad 0",
                         addrs[i], n_strobe, n_bad, exp_ws[i] + 1);
            end
            next_cycle();
            IO_Op = 2'b00;
            if (ops[i] != 2'b01)
                last_rd = rd;
            checks++;
            if (DI !== last_rd) begin
                errors++;
                $display("FAIL region_di[%h] got %h want %h", addrs[i], DI, last_rd);
            end
            @(negedge Clk);
            checks++;
            if (MemCE !== 1'b0) begin
                errors++;
                $display("FAIL region_end[%h] got ce=%b want 0", addrs[i], MemCE);
            end
            next_cycle();
        end
    endtask

    task automatic test_contention();
        IO_Op = 2'b10; AO = 16'h0100; MemDI = 8'h11;
        DMA_Req = 1'b1; DMA_Wr = 1'b1; DMA_Addr = 16'h0400; DMA_DO = 8'h99;
        for (int i = 0; i < 6; i++) begin
            logic        exp_dma;
            logic [15:0] exp_a;
            exp_dma = (i % 2 == 0);
            exp_a   = exp_dma ? 16'h0400 : 16'h0100;
            @(negedge Clk);
            checks++;
            if ({DMA_Ack, Wait, MemWE, MemA} !== {exp_dma, exp_dma, exp_dma, exp_a} ||
                (exp_dma && MemDO !== 8'h99)) begin
                errors++;
                $display("FAIL contention[%0d] got ack/wait/we=%b%b%b a=%h do=%h want %b%b%b a=%h",
                         i, DMA_Ack, Wait, MemWE, MemA, MemDO, exp_dma, exp_dma, exp_dma, exp_a);
            end
            next_cycle();
        end
        IO_Op = 2'b00; DMA_Req = 1'b0;
        checks++;
        if (DI !== 8'h11) begin
            errors++;
            $display("FAIL contention_di got %h want 11", DI);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic        exp_ack [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        exp_wait[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] exp_a   [7] = '{16'hF100, 16'hF100, 16'hF100, 16'h0100,
                                     16'hF100, 16'hF100, 16'hF100};
        IO_Op = 2'b10; AO = 16'h0100; MemDI = 8'h42;
        DMA_Req = 1'b1; DMA_Wr = 1'b0; DMA_Addr = 16'hF100;
        for (int i = 0; i < 7; i++) begin
            @(negedge Clk);
            checks++;
            if ({DMA_Ack, Wait, MemCE, MemA} !== {exp_ack[i], exp_wait[i], 1'b1, exp_a[i]}) begin
                errors++;
                $display("FAIL back_to_back[%0d] got ack/wait/ce=%b%b%b a=%h want %b%b1 a=%h",
                         i, DMA_Ack, Wait, MemCE, MemA, exp_ack[i], exp_wait[i], exp_a[i]);
            end
            next_cycle();
        end
        IO_Op = 2'b00; DMA_Req = 1'b0;
        checks++;
        if (DMA_DI !== 8'h42) begin
            errors++;
            $display("FAIL back_to_back_dma_di got %h want 42", DMA_DI);
        end
        next_cycle();
    endtask

    task automatic test_lock();
        int n_ack;
        int n_ce;
        n_ack = 0; n_ce = 0;
        Lock = 1'b1; DMA_Req = 1'b1; DMA_Wr = 1'b0; DMA_Addr = 16'h0500; MemDI = 8'h66;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (DMA_Ack === 1'b1) n_ack++;
            if (MemCE === 1'b1)   n_ce++;
            next_cycle();
        end
        checks++;
        if (n_ack != 0 || n_ce != 0) begin
            errors++;
            $display("FAIL lock_block got acks %0d ce %0d want 0 0", n_ack, n_ce);
        end
        Lock = 1'b0;
        @(negedge Clk);
        checks++;
        if ({DMA_Ack, MemA} !== {1'b1, 16'h0500}) begin
            errors++;
            $display("FAIL lock_release got ack=%b a=%h want 1 0500", DMA_Ack, MemA);
        end
        next_cycle();
        DMA_Addr = 16'hF200;
        @(negedge Clk);
        checks++;
        if ({MemCE, DMA_Ack, MemA} !== {2'b10, 16'hF200}) begin
            errors++;
            $display("FAIL lock_mid_c1 got ce/ack=%b%b a=%h want 10 f200", MemCE, DMA_Ack, MemA);
        end
        next_cycle();
        Lock = 1'b1;
        @(negedge Clk);
        checks++;
        if ({MemCE, DMA_Ack} !== 2'b10) begin
            errors++;
            $display("FAIL lock_mid_c2 got ce/ack=%b%b want 10", MemCE, DMA_Ack);
        end
        next_cycle();
        @(negedge Clk);
        checks++;
        if ({DMA_Ack, MemA} !== {1'b1, 16'hF200}) begin
            errors++;
            $display("FAIL lock_mid_c3 got ack=%b a=%h want 1 f200", DMA_Ack, MemA);
        end
        next_cycle();
        DMA_Req = 1'b0; Lock = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_abort();
        IO_Op = 2'b10; AO = 16'hFFF0; MemDI = 8'hEE;
        @(negedge Clk);
        checks++;
        if ({Wait, MemCE} !== 2'b11) begin
            errors++;
            $display("FAIL abort_c1 got wait/ce=%b%b want 11", Wait, MemCE);
        end
        next_cycle();
        nRst = 1'b0;
        #1;
        checks++;
        if ({MemCE, MemOE, Wait, DI} !== 11'h0) begin
            errors++;
            $display("FAIL abort_drop got ce/oe/wait=%b%b%b di=%h want 000 00", MemCE, MemOE, Wait, DI);
        end
        next_cycle();
        IO_Op = 2'b00;
        nRst  = 1'b1;
        @(negedge Clk);
        checks++;
        if (MemCE !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got ce=%b want 0", MemCE);
        end
        next_cycle();
        checks++;
        if (DI !== 8'h00) begin
            errors++;
            $display("FAIL abort_di got %h want 00", DI);
        end
        IO_Op = 2'b10; AO = 16'h0200; MemDI = 8'h5A;
        @(negedge Clk);
        checks++;
        if ({Wait, MemOE} !== 2'b01) begin
            errors++;
            $display("FAIL abort_regrant got wait/oe=%b%b want 01", Wait, MemOE);
        end
        next_cycle();
        IO_Op = 2'b00;
        checks++;
        if (DI !== 8'h5A) begin
            errors++;
            $display("FAIL abort_regrant_di got %h want 5a", DI);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_regions();
        test_contention();
        test_back_to_back();
        test_lock();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
